iq_bin_scheduler: RTL and testbench

- Time-shares one external bin_binary_search engine between the I and Q channels of each measurement sample.
- Serializes each sample pair through the engine, I first then Q, and emits one 2-D bin result (i_bin, q_bin) per pair.
- Feeds the downstream 2-D histogram accumulator.
- Holds one pending sample pair while busy; counts dropped samples; flags engine timeouts.

---
 rtl/iq_bin_scheduler_if.sv | 40 ++++
 rtl/iq_bin_scheduler.sv | 140 ++++++++++++++
 tb/tb_iq_bin_scheduler.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/iq_bin_scheduler_if.sv
// iq_bin_scheduler_if: sample input, bin-engine and pair-result signals of the I/Q bin scheduler
interface iq_bin_scheduler_if #(
    parameter int CNT_W = 16
);
    logic               sample_valid;
    logic signed [31:0] i_val;
    logic signed [31:0] q_val;
    logic signed [15:0] i_origin;
    logic signed [15:0] q_origin;
    logic [15:0]        i_bin_width;
    logic [15:0]        q_bin_width;
    logic [5:0]         num_bins;
    logic               bs_start;
    logic [31:0]        bs_value;
    logic [15:0]        bs_origin;
    logic [15:0]        bs_bin_width;
    logic [5:0]         bs_num_bins;
    logic               bs_binned;
    logic [5:0]         bs_current;
    logic               pair_valid;
    logic [5:0]         i_bin;
    logic [5:0]         q_bin;
    logic               busy;
    logic [CNT_W-1:0]   dropped_count;
    logic               timeout_err;

    modport slave (
        input  sample_valid, i_val, q_val, i_origin, q_origin, i_bin_width, q_bin_width, num_bins,
        input  bs_binned, bs_current,
        output bs_start, bs_value, bs_origin, bs_bin_width, bs_num_bins,
        output pair_valid, i_bin, q_bin, busy, dropped_count, timeout_err
    );

    modport master (
        output sample_valid, i_val, q_val, i_origin, q_origin, i_bin_width, q_bin_width, num_bins,
        output bs_binned, bs_current,
        input  bs_start, bs_value, bs_origin, bs_bin_width, bs_num_bins,
        input  pair_valid, i_bin, q_bin, busy, dropped_count, timeout_err
    );
endinterface

// File: rtl/iq_bin_scheduler.sv
// iq_bin_scheduler: time-shares one bin search engine between the I and Q axes of each sample pair
module iq_bin_scheduler #(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int CNT_W = 16
) (
    input logic               clk100,
    input logic               rst,
    iq_bin_scheduler_if.slave bus
);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {S_IDLE, S_START_I, S_WAIT_I, S_START_Q, S_WAIT_Q, S_DONE} state_t;

    typedef struct packed {
        logic [31:0] iv;
        logic [31:0] qv;
        logic [15:0] io;
        logic [15:0] qo;
        logic [15:0] iw;
        logic [15:0] qw;
        logic [5:0]  nb;
    } set_t;

    state_t           r_state;
    set_t             r_work;
    set_t             r_pend;
    logic             r_pend_full;
    logic [TW-1:0]    r_tmo;
    logic [5:0]       r_i_res;
    logic             r_bs_start;
    logic             r_pair_valid;
    logic [5:0]       r_i_bin;
    logic [5:0]       r_q_bin;
    logic             r_timeout_err;
    logic [CNT_W-1:0] r_drop;

    set_t             w_in;
    set_t             w_load;
    logic             w_go;
    logic             w_ev;
    logic [5:0]       w_res;
    logic             w_q_axis;

    assign w_in   = {bus.i_val, bus.q_val, bus.i_origin, bus.q_origin, bus.i_bin_width, bus.q_bin_width, bus.num_bins};
    assign w_load = (r_state == S_DONE && r_pend_full) ? r_pend : w_in;
    assign w_go   = (r_state == S_IDLE && bus.sample_valid) || (r_state == S_DONE && (r_pend_full || bus.sample_valid));
    assign w_ev   = bus.bs_binned || (r_tmo == TW'(TIMEOUT_CYCLES - 1));
    assign w_res  = bus.bs_binned ? bus.bs_current : 6'h3F;
    assign w_q_axis = (r_state == S_START_Q) || (r_state == S_WAIT_Q);

    assign bus.bs_start      = r_bs_start;
    assign bus.bs_value      = w_q_axis ? r_work.qv : r_work.iv;
    assign bus.bs_origin     = w_q_axis ? r_work.qo : r_work.io;
    assign bus.bs_bin_width  = w_q_axis ? r_work.qw : r_work.iw;
    assign bus.bs_num_bins   = r_work.nb;
    assign bus.pair_valid    = r_pair_valid;
    assign bus.i_bin         = r_i_bin;
    assign bus.q_bin         = r_q_bin;
    assign bus.busy          = (r_state != S_IDLE);
    assign bus.dropped_count = r_drop;
    assign bus.timeout_err   = r_timeout_err;

    // Sequencer: capture a working set, run the engine on I then Q, publish the pair
    always_ff @(posedge clk100 or posedge rst) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_work        <= '0;
            r_tmo         <= '0;
            r_i_res       <= '0;
            r_bs_start    <= 1'b0;
            r_pair_valid  <= 1'b0;
            r_i_bin       <= '0;
            r_q_bin       <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            r_bs_start   <= 1'b0;
            r_pair_valid <= 1'b0;
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (w_go) begin
                        r_work     <= w_load;
                        r_bs_start <= 1'b1;
                        r_state    <= S_START_I;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_START_I: begin
                    r_tmo   <= '0;
                    r_state <= S_WAIT_I;
                end
                S_WAIT_I: begin
                    if (w_ev) begin
                        r_i_res       <= w_res;
                        r_timeout_err <= r_timeout_err | ~bus.bs_binned;
                        r_bs_start    <= 1'b1;
                        r_state       <= S_START_Q;
                    end else begin
                        r_tmo <= r_tmo + 1'b1;
                    end
                end
                S_START_Q: begin
                    r_tmo   <= '0;
                    r_state <= S_WAIT_Q;
                end
                S_WAIT_Q: begin
                    if (w_ev) begin
                        r_i_bin       <= r_i_res;
                        r_q_bin       <= w_res;
                        r_timeout_err <= r_timeout_err | ~bus.bs_binned;
                        r_pair_valid  <= 1'b1;
                        r_state       <= S_DONE;
                    end else begin
                        r_tmo <= r_tmo + 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // One-deep pending buffer for arrivals while busy; further arrivals are counted as dropped
    always_ff @(posedge clk100 or posedge rst) begin
        if (rst) begin
            r_pend      <= '0;
            r_pend_full <= 1'b0;
            r_drop      <= '0;
        end else if (r_state == S_DONE && r_pend_full) begin
            r_pend      <= w_in;
            r_pend_full <= bus.sample_valid;
        end else if (bus.sample_valid && r_state != S_IDLE && r_state != S_DONE) begin
            if (!r_pend_full) begin
                r_pend      <= w_in;
                r_pend_full <= 1'b1;
            end else if (r_drop != '1) begin
                r_drop <= r_drop + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_iq_bin_scheduler.sv
// tb_iq_bin_scheduler: scoreboard bench with an 8-cycle bin engine model
module tb_iq_bin_scheduler;
    logic clk100 = 1'b0;
    logic rst = 1'b1;

    iq_bin_scheduler_if bus();

    iq_bin_scheduler dut (
        .clk100(clk100),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk100 = ~clk100;

    typedef struct {
        logic [5:0] i;
        logic [5:0] q;
        int         cyc;
        logic       tmo;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] st_val[$];
    logic [15:0] st_org[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          n_start = 0;
    int          mute_at = -1;
    int          base;
    bit          sb_off = 1'b0;

    always @(posedge clk100) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", nm, act, exp);
        end
    endtask

    task automatic strobe(input logic [31:0] iv, input logic [31:0] qv, input bit push,
                          input int lat, input logic [5:0] qexp, input logic tmo);
        exp_t e;
        @(posedge clk100);
        #1;
        bus.sample_valid = 1'b1;
        bus.i_val = iv;
        bus.q_val = qv;
        if (push) begin
            e.i = iv[5:0];
            e.q = qexp;
            e.cyc = cyc + lat;
            e.tmo = tmo;
            sb.push_back(e);
        end
        @(posedge clk100);
        #1 bus.sample_valid = 1'b0;
    endtask

    task automatic wait_idle(input string nm);
        int n = 0;
        @(negedge clk100);
        while (bus.busy && n < 400) begin
            @(negedge clk100);
            n++;
        end
        chk({nm, "_idle"}, 32'(bus.busy), 0);
        @(negedge clk100);
        chk({nm, "_drain"}, 32'(sb.size()), 0);
    endtask

    // Engine model: answers value[5:0] eight cycles after a start, unless muted
    initial begin
        logic [5:0] v;
        bus.bs_binned = 1'b0;
        bus.bs_current = '0;
        forever begin
            @(negedge clk100);
            if (bus.bs_start) begin
                n_start++;
                st_val.push_back(bus.bs_value);
                st_org.push_back(bus.bs_origin);
                if (n_start != mute_at) begin
                    v = bus.bs_value[5:0];
                    repeat (8) @(posedge clk100);
                    #1;
                    bus.bs_binned = 1'b1;
                    bus.bs_current = v;
                    @(posedge clk100);
                    #1 bus.bs_binned = 1'b0;
                end
            end
        end
    end

    // Monitor: every pair_valid is matched against the next scoreboard entry
    always @(negedge clk100) begin
        exp_t e;
        if (!rst && bus.pair_valid && !sb_off) begin
            if (sb.size() == 0) begin
                chk("unexpected_pair", 32'(bus.pair_valid), 0);
            end else begin
                e = sb.pop_front();
                chk("pair_i", 32'(bus.i_bin), 32'(e.i));
                chk("pair_q", 32'(bus.q_bin), 32'(e.q));
                chk("pair_cycle", cyc, e.cyc);
                chk("pair_timeout_err", 32'(bus.timeout_err), 32'(e.tmo));
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        bus.sample_valid = 1'b0;
        bus.i_val = '0;
        bus.q_val = '0;
        bus.i_origin = 16'sd12;
        bus.q_origin = -16'sd4;
        bus.i_bin_width = 16'd4;
        bus.q_bin_width = 16'd4;
        bus.num_bins = 6'd32;
        repeat (3) @(posedge clk100);
        #1;
        chk("rst_pair_valid", 32'(bus.pair_valid), 0);
        chk("rst_bs_start", 32'(bus.bs_start), 0);
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_i_bin", 32'(bus.i_bin), 0);
        chk("rst_q_bin", 32'(bus.q_bin), 0);
        chk("rst_dropped", 32'(bus.dropped_count), 0);
        chk("rst_timeout_err", 32'(bus.timeout_err), 0);
        chk("rst_bs_value", bus.bs_value, 0);
        rst = 1'b0;
        repeat (2) @(posedge clk100);

        st_val.delete();
        st_org.delete();
        base = n_start;
        strobe(32'd5, 32'hFFFF_FFFD, 1'b1, 19, 6'h3D, 1'b0);
        wait_idle("single");
        chk("single_starts", 32'(n_start - base), 2);
        chk("single_start_i_value", st_val[0], 32'd5);
        chk("single_start_i_origin", 32'(st_org[0]), 32'h000C);
        chk("single_start_q_value", st_val[1], 32'hFFFF_FFFD);
        chk("single_start_q_origin", 32'(st_org[1]), 32'hFFFC);

        strobe(32'd1, 32'd2, 1'b1, 19, 6'd2, 1'b0);
        repeat (2) @(posedge clk100);
        strobe(32'd3, 32'd4, 1'b1, 34, 6'd4, 1'b0);
        wait_idle("b2b");
        chk("b2b_dropped", 32'(bus.dropped_count), 0);

        strobe(32'd7, 32'd8, 1'b1, 19, 6'd8, 1'b0);
        strobe(32'd9, 32'd10, 1'b1, 36, 6'd10, 1'b0);
        strobe(32'd11, 32'd12, 1'b0, 0, 6'd0, 1'b0);
        wait_idle("ovf");
        chk("ovf_dropped", 32'(bus.dropped_count), 1);

        bus.i_origin = 16'sd0;
        bus.q_origin = 16'sd7;
        st_org.delete();
        strobe(32'd6, 32'd2, 1'b1, 19, 6'd2, 1'b0);
        repeat (4) @(posedge clk100);
        #1 bus.i_origin = 16'sd100;
        repeat (2) @(posedge clk100);
        #1 chk("cfg_hold_origin", 32'(bus.bs_origin), 0);
        wait_idle("cfg");
        chk("cfg_starts", 32'(st_org.size()), 2);
        chk("cfg_i_origin", 32'(st_org[0]), 0);
        chk("cfg_q_origin", 32'(st_org[1]), 7);
        st_org.delete();
        strobe(32'd6, 32'd2, 1'b1, 19, 6'd2, 1'b0);
        wait_idle("cfg2");
        chk("cfg2_i_origin", 32'(st_org[0]), 100);

        mute_at = n_start + 2;
        strobe(32'd13, 32'd14, 1'b1, 75, 6'h3F, 1'b1);
        wait_idle("tmo");
        mute_at = -1;
        chk("tmo_err_sticky", 32'(bus.timeout_err), 1);
        chk("tmo_i_bin_held", 32'(bus.i_bin), 13);

        sb_off = 1'b1;
        @(posedge clk100);
        #1 bus.sample_valid = 1'b1;
        repeat (70000) @(posedge clk100);
        #1 bus.sample_valid = 1'b0;
        wait_idle("flood");
        sb_off = 1'b0;
        chk("flood_saturated", 32'(bus.dropped_count), 32'hFFFF);
        chk("flood_timeout_err", 32'(bus.timeout_err), 1);

        strobe(32'd10, 32'd11, 1'b0, 0, 6'd0, 1'b0);
        strobe(32'd12, 32'd13, 1'b0, 0, 6'd0, 1'b0);
        repeat (10) @(posedge clk100);
        #1 chk("midop_busy", 32'(bus.busy), 1);
        #2 rst = 1'b1;
        #1;
        chk("midop_pair_valid", 32'(bus.pair_valid), 0);
        chk("midop_busy_rst", 32'(bus.busy), 0);
        chk("midop_bs_start", 32'(bus.bs_start), 0);
        chk("midop_i_bin", 32'(bus.i_bin), 0);
        chk("midop_q_bin", 32'(bus.q_bin), 0);
        chk("midop_dropped", 32'(bus.dropped_count), 0);
        chk("midop_timeout_err", 32'(bus.timeout_err), 0);
        chk("midop_bs_value", bus.bs_value, 0);
        repeat (3) @(posedge clk100);
        #1 rst = 1'b0;
        repeat (12) @(posedge clk100);
        #1 chk("post_rst_idle", 32'(bus.busy), 0);
        strobe(32'd20, 32'd21, 1'b1, 19, 6'd21, 1'b0);
        wait_idle("post_rst");
        chk("post_rst_dropped", 32'(bus.dropped_count), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
